// File: rtl/jtpopeye_busarb_if.sv
// jtpopeye_busarb_if: CPU, video DMA and sprite-RAM signals around the bus arbiter
interface jtpopeye_busarb_if;
    logic       cpu_cen, cpu_busy, cpu_we;
    logic [9:0] cpu_addr;
    logic [7:0] cpu_dout;
    logic       busrq_n, busak_n, cpu_hold;
    logic       dma_cs, dma_ovr;
    logic [9:0] AD_DMA, ram_addr;
    logic [7:0] DD_DMA, ram_din, ram_dout;
    logic       ram_we;
    modport slave (
        input  cpu_cen, cpu_busy, cpu_addr, cpu_we, cpu_dout, busrq_n, dma_cs, AD_DMA, ram_dout,
        output busak_n, cpu_hold, DD_DMA, ram_addr, ram_we, ram_din, dma_ovr
    );
    modport master (
        output cpu_cen, cpu_busy, cpu_addr, cpu_we, cpu_dout, busrq_n, dma_cs, AD_DMA, ram_dout,
        input  busak_n, cpu_hold, DD_DMA, ram_addr, ram_we, ram_din, dma_ovr
    );
endinterface

// File: rtl/jtpopeye_busarb.sv
// jtpopeye_busarb: grants the sprite-RAM bus to the video DMA and stalls the CPU meanwhile
module jtpopeye_busarb #(
    parameter int HOLD_MAX = 1023
) (
    input  logic             clk,
    input  logic             rst,
    jtpopeye_busarb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, GRANT, RELEASE} state_t;
    state_t      state_q, state_d;
    logic        busak_n_q, busak_n_d;
    logic        cpu_hold_q, cpu_hold_d;
    logic        rd_pend_q, rd_pend_d;
    logic        dma_ovr_q, dma_ovr_d;
    logic [7:0]  dd_q, dd_d;
    logic [10:0] cnt_q, cnt_d;
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.busrq_n ? IDLE : WAIT;
            WAIT:    state_d = bus.busrq_n ? IDLE : (bus.cpu_cen && !bus.cpu_busy) ? GRANT : WAIT;
            GRANT:   state_d = bus.busrq_n ? RELEASE : GRANT;
            RELEASE: state_d = bus.cpu_cen ? IDLE : RELEASE;
            default: state_d = IDLE;
        endcase
        // handshake outputs are registered images of the next state
        busak_n_d  = state_d != GRANT;
        cpu_hold_d = state_d == GRANT || state_d == RELEASE;
        rd_pend_d  = state_q == GRANT && bus.dma_cs;
        dd_d       = rd_pend_q ? bus.ram_dout : dd_q;
        cnt_d      = state_q != GRANT ? (state_d == GRANT ? 11'd0 : cnt_q)
                   : (cnt_q == 11'h7FF ? cnt_q : cnt_q + 11'd1);
        dma_ovr_d  = dma_ovr_q || (state_q == GRANT && cnt_d == 11'(HOLD_MAX));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            busak_n_q  <= 1'b1;
            cpu_hold_q <= 1'b0;
            rd_pend_q  <= 1'b0;
            dma_ovr_q  <= 1'b0;
            dd_q       <= 8'd0;
            cnt_q      <= 11'd0;
        end else begin
            state_q    <= state_d;
            busak_n_q  <= busak_n_d;
            cpu_hold_q <= cpu_hold_d;
            rd_pend_q  <= rd_pend_d;
            dma_ovr_q  <= dma_ovr_d;
            dd_q       <= dd_d;
            cnt_q      <= cnt_d;
        end
    end
    assign bus.busak_n  = busak_n_q;
    assign bus.cpu_hold = cpu_hold_q;
    assign bus.DD_DMA   = dd_q;
    assign bus.dma_ovr  = dma_ovr_q;
    assign bus.ram_addr = state_q == GRANT ? bus.AD_DMA : bus.cpu_addr;
    assign bus.ram_we   = bus.cpu_we && (state_q == IDLE || state_q == WAIT);
    assign bus.ram_din  = bus.cpu_dout;
endmodule

// File: tb/tb_jtpopeye_busarb.sv
// tb_jtpopeye_busarb: directed and random checks of the bus arbiter against a reference model
module tb_jtpopeye_busarb;
    localparam int HOLD = 16;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    jtpopeye_busarb_if bus();
    jtpopeye_busarb #(.HOLD_MAX(HOLD)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    logic [7:0] mem [1024];
    logic [7:0] ref_mem [1024];
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
        bus.ram_dout <= mem[bus.ram_addr];
    end
    bit         m_wait, m_grant, m_rel, m_ovr, m_pend;
    int         m_len;
    logic [7:0] m_dd, m_pdata;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask
    task automatic model_step();
        logic [7:0] rd = ref_mem[bus.AD_DMA];
        bit nxt_pend = m_grant && bus.dma_cs;
        if (bus.cpu_we && !m_grant && !m_rel) ref_mem[bus.cpu_addr] = bus.cpu_dout;
        if (m_pend) m_dd = m_pdata;
        m_pend  = nxt_pend;
        m_pdata = rd;
        if (m_grant) begin
            if (m_len < 2047) m_len++;
            if (m_len == HOLD) m_ovr = 1;
            if (bus.busrq_n) begin m_grant = 0; m_rel = 1; end
        end else if (m_rel) begin
            if (bus.cpu_cen) m_rel = 0;
        end else if (m_wait) begin
            if (bus.busrq_n) m_wait = 0;
            else if (bus.cpu_cen && !bus.cpu_busy) begin m_wait = 0; m_grant = 1; m_len = 0; end
        end else if (!bus.busrq_n) m_wait = 1;
        if (rst) begin
            m_wait = 0; m_grant = 0; m_rel = 0; m_ovr = 0; m_pend = 0; m_len = 0; m_dd = 8'd0;
        end
    endtask
    task automatic tick();
        #1;
        chk("ram_addr", bus.ram_addr, m_grant ? bus.AD_DMA : bus.cpu_addr);
        chk("ram_we", bus.ram_we, bus.cpu_we && !m_grant && !m_rel);
        chk("ram_din", bus.ram_din, bus.cpu_dout);
        model_step();
        @(negedge clk);
        chk("busak_n", bus.busak_n, !m_grant);
        chk("cpu_hold", bus.cpu_hold, m_grant || m_rel);
        chk("DD_DMA", bus.DD_DMA, m_dd);
        chk("dma_ovr", bus.dma_ovr, m_ovr);
        cyc++;
    endtask
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            bus.cpu_cen = (cyc % 4 == 0);
            tick();
        end
    endtask
    task automatic wait_busak(input logic lvl, input int bound, input string tag);
        int n = 0;
        while (bus.busak_n !== lvl && n < bound) begin run(1); n++; end
        chk(tag, bus.busak_n, lvl);
    endtask
    task automatic wait_hold(input logic lvl, input int bound, input string tag);
        int n = 0;
        while (bus.cpu_hold !== lvl && n < bound) begin run(1); n++; end
        chk(tag, bus.cpu_hold, lvl);
    endtask
    initial begin
        bit saw;
        rst = 1'b1;
        bus.cpu_cen = 0; bus.cpu_busy = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_dout = 0;
        bus.busrq_n = 1; bus.dma_cs = 0; bus.AD_DMA = 0;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[10'h155] = 8'hA7; ref_mem[10'h155] = 8'hA7;
        mem[10'h010] = 8'h00; ref_mem[10'h010] = 8'h00;
        @(negedge clk);
        tick();
        rst = 1'b0;
        chk("reset_busak_n", bus.busak_n, 1'b1);
        chk("reset_hold", bus.cpu_hold, 1'b0);
        chk("reset_dd", bus.DD_DMA, 8'd0);
        run(3);
        // idle request and release
        bus.busrq_n = 0;
        wait_busak(1'b0, 5, "grant_latency");
        chk("grant_hold", bus.cpu_hold, 1'b1);
        run(4);
        bus.busrq_n = 1;
        run(1);
        chk("release_ack", bus.busak_n, 1'b1);
        wait_hold(1'b0, 8, "release_hold");
        run(2);
        // busy CPU defers the grant
        bus.cpu_busy = 1;
        bus.busrq_n = 0;
        for (int i = 0; i < 20; i++) begin
            run(1);
            chk("busy_no_grant", bus.busak_n, 1'b1);
        end
        bus.cpu_busy = 0;
        wait_busak(1'b0, 8, "busy_grant");
        // DMA read and blocked CPU write during the grant
        bus.AD_DMA = 10'h155;
        bus.dma_cs = 1;
        run(1);
        bus.dma_cs = 0;
        run(1);
        chk("dma_read", bus.DD_DMA, 8'hA7);
        bus.AD_DMA = 10'h0F0;
        run(3);
        chk("dma_held", bus.DD_DMA, 8'hA7);
        bus.cpu_addr = 10'h010; bus.cpu_dout = 8'h3C; bus.cpu_we = 1;
        #1 chk("we_blocked", bus.ram_we, 1'b0);
        run(1);
        bus.cpu_we = 0;
        bus.busrq_n = 1;
        wait_hold(1'b0, 10, "release2_hold");
        chk("ram_unchanged", mem[10'h010], 8'h00);
        bus.dma_cs = 1; bus.AD_DMA = 10'h020;
        run(3);
        bus.dma_cs = 0;
        chk("idle_cs_ignored", bus.DD_DMA, 8'hA7);
        bus.cpu_we = 1;
        run(1);
        bus.cpu_we = 0;
        chk("idle_write", mem[10'h010], 8'h3C);
        // overrun
        chk("ovr_clear", bus.dma_ovr, 1'b0);
        bus.busrq_n = 0;
        run(40);
        chk("ovr_set", bus.dma_ovr, 1'b1);
        bus.busrq_n = 1;
        wait_hold(1'b0, 10, "ovr_release");
        chk("ovr_sticky", bus.dma_ovr, 1'b1);
        rst = 1;
        run(1);
        rst = 0;
        chk("ovr_reset", bus.dma_ovr, 1'b0);
        // withdrawn request while busy
        bus.cpu_busy = 1;
        bus.busrq_n = 0;
        run(1);
        bus.busrq_n = 1;
        saw = 0;
        for (int i = 0; i < 10; i++) begin
            run(1);
            if (!bus.busak_n) saw = 1;
        end
        chk("withdraw_no_grant", saw, 1'b0);
        bus.cpu_busy = 0;
        // reset in the middle of a grant
        bus.busrq_n = 0;
        wait_busak(1'b0, 8, "pre_reset_grant");
        bus.AD_DMA = 10'h155; bus.dma_cs = 1;
        run(3);
        bus.dma_cs = 0;
        rst = 1;
        run(1);
        rst = 0;
        bus.busrq_n = 1;
        chk("rst_busak_n", bus.busak_n, 1'b1);
        chk("rst_hold", bus.cpu_hold, 1'b0);
        chk("rst_dd", bus.DD_DMA, 8'd0);
        run(2);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 7) == 0) bus.busrq_n = ~bus.busrq_n;
            bus.cpu_cen  = ($urandom_range(0, 2) == 0);
            bus.cpu_busy = ($urandom_range(0, 3) == 0);
            bus.cpu_we   = ($urandom_range(0, 3) == 0);
            bus.cpu_addr = 10'($urandom);
            bus.cpu_dout = 8'($urandom);
            bus.dma_cs   = 1'($urandom);
            bus.AD_DMA   = 10'($urandom);
            tick();
        end
        rst = 0; bus.cpu_we = 0;
        run(2);
        for (int i = 0; i < 1024; i++) chk("ram_contents", mem[i], ref_mem[i]);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
